// File: rtl/rv_pkg.sv
// Shared definitions for the register-file writeback path: widths, the x0
// constant, the writeback request record and the arbiter's priority state.
package rv_pkg;

    localparam int RV_DATA_W = 32;
    localparam int RV_ADDR_W = 5;

    localparam logic [RV_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                 valid;
        logic [RV_ADDR_W-1:0] dest;
        logic [RV_DATA_W-1:0] data;
    } wb_req_t;

    // Encoding equals the round-robin pointer: the value is the channel granted last.
    typedef enum logic {
        PRI1 = 1'b0,
        PRI0 = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry writeback holding buffer with valid/ready handshake.
// Requests targeting x0 are accepted but dropped, so they never reach the scheduler.
module wb_hold_buf
    import rv_pkg::*;
#(
    parameter int DATA_W = RV_DATA_W,
    parameter int ADDR_W = RV_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_dest,
    input  logic [DATA_W-1:0] req_data,
    input  logic              grant,
    output logic              req_ready,
    output logic              full,
    output logic [ADDR_W-1:0] dest,
    output logic [DATA_W-1:0] data
);

    logic accept;
    logic load;

    // A buffer being drained this cycle can take a new request on the same edge.
    assign req_ready = !full || grant;
    assign accept    = req_valid && req_ready && !flush;
    assign load      = accept && (req_dest != ADDR_W'(REG_ZERO));

    // Occupancy and contents; a refill takes precedence over the drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            dest <= '0;
            data <= '0;
        end else begin
            if (flush) begin
                full <= 1'b0;
            end else if (load) begin
                full <= 1'b1;
            end else if (grant) begin
                full <= 1'b0;
            end
            if (load) begin
                dest <= req_dest;
                data <= req_data;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// (channel 0) and load (channel 1) writeback paths, with read-after-write
// hazard flags for the two read addresses.
module regfile_wb_arbiter
    import rv_pkg::*;
#(
    parameter int DATA_W = RV_DATA_W,
    parameter int ADDR_W = RV_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Req0_Valid,
    input  logic [ADDR_W-1:0] Req0_Dest,
    input  logic [DATA_W-1:0] Req0_Data,
    output logic              Req0_Ready,
    input  logic              Req1_Valid,
    input  logic [ADDR_W-1:0] Req1_Dest,
    input  logic [DATA_W-1:0] Req1_Data,
    output logic              Req1_Ready,
    input  logic              Flush,
    input  logic [ADDR_W-1:0] Add_A,
    input  logic [ADDR_W-1:0] Add_B,
    output logic              Hazard_A,
    output logic              Hazard_B,
    output logic [ADDR_W-1:0] Add_Dest,
    output logic [DATA_W-1:0] Write_Data,
    output logic              Write_En
);

    logic              full0, full1;
    logic [ADDR_W-1:0] dest0, dest1;
    logic [DATA_W-1:0] data0, data1;
    logic              grant0, grant1;
    arb_state_e        state_q, state_d;

    wb_hold_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf0 (
        .clk       (CLK),
        .rst       (RST),
        .flush     (Flush),
        .req_valid (Req0_Valid),
        .req_dest  (Req0_Dest),
        .req_data  (Req0_Data),
        .grant     (grant0),
        .req_ready (Req0_Ready),
        .full      (full0),
        .dest      (dest0),
        .data      (data0)
    );

    wb_hold_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf1 (
        .clk       (CLK),
        .rst       (RST),
        .flush     (Flush),
        .req_valid (Req1_Valid),
        .req_dest  (Req1_Dest),
        .req_data  (Req1_Data),
        .grant     (grant1),
        .req_ready (Req1_Ready),
        .full      (full1),
        .dest      (dest1),
        .data      (data1)
    );

    // Round-robin pointer register; channel 0 wins the first contention.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= PRI0;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant selection and pointer update; a flush blocks grants and freezes the pointer.
    always_comb begin
        grant0  = 1'b0;
        grant1  = 1'b0;
        state_d = state_q;
        if (!Flush) begin
            if (full0 && (!full1 || state_q == PRI0)) begin
                grant0 = 1'b1;
            end else if (full1) begin
                grant1 = 1'b1;
            end
        end
        if (grant0) begin
            state_d = PRI1;
        end else if (grant1) begin
            state_d = PRI0;
        end
    end

    // Registered write port; address and data hold when idle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Write_En   <= 1'b0;
            Add_Dest   <= '0;
            Write_Data <= '0;
        end else if (grant0) begin
            Write_En   <= 1'b1;
            Add_Dest   <= dest0;
            Write_Data <= data0;
        end else if (grant1) begin
            Write_En   <= 1'b1;
            Add_Dest   <= dest1;
            Write_Data <= data1;
        end else begin
            Write_En   <= 1'b0;
        end
    end

    // x0 reads never stall since x0 is never written.
    assign Hazard_A = (Add_A != ADDR_W'(REG_ZERO)) &&
                      ((full0 && Add_A == dest0) ||
                       (full1 && Add_A == dest1) ||
                       (Write_En && Add_A == Add_Dest));

    assign Hazard_B = (Add_B != ADDR_W'(REG_ZERO)) &&
                      ((full0 && Add_B == dest0) ||
                       (full1 && Add_B == dest1) ||
                       (Write_En && Add_B == Add_Dest));

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Arbiter that shares the single write port of the RISC-V `Register_File` between two writeback requesters: the ALU result path (channel 0) and the load/memory result path (channel 1). Each channel has a valid/ready handshake and a one-entry holding buffer. A round-robin scheduler drives `Add_Dest`, `Write_Data` and `Write_En` into the register file, and the block suppresses writes to x0. It also flags read-after-write hazards on the two register-file read addresses, so the decode stage can stall.

## Interface
- `DATA_W`, default 32: width of the writeback data.
- `ADDR_W`, default 5: width of a register address (32 registers).
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `Req0_Valid`  in  1  ALU writeback request valid.
- `Req0_Dest`  in  ADDR_W  ALU destination register.
- `Req0_Data`  in  DATA_W  ALU result.
- `Req0_Ready`  out  1  channel 0 can accept a request this cycle.
- `Req1_Valid`, `Req1_Dest`, `Req1_Data`, `Req1_Ready`: same as channel 0, for the load path.
- `Flush`  in  1  synchronous clear of both holding buffers.
- `Add_A`, `Add_B`  in  ADDR_W  register-file read addresses (hazard check only).
- `Hazard_A`, `Hazard_B`  out  1  read address matches a pending write.
- `Add_Dest`  out  ADDR_W  write address to the register file (registered).
- `Write_Data`  out  DATA_W  write data to the register file (registered).
- `Write_En`  out  1  write strobe to the register file (registered).

## Operation
**Buffers**
- Each channel has one holding buffer: `Full`, `Dest`, `Data`.
- Acceptance happens when Valid && Ready at a rising edge.
- `ReqN_Ready` = !FullN || GrantN. The grant is combinational in the same cycle, so a draining buffer can be refilled back to back.
- A request with Dest == 0 is accepted (Ready behaves normally) but discarded. The buffer is not filled and no write is issued.

**Scheduler**
- The round-robin pointer `Last` (1 bit) is the only state. There are two states, PRI0 (`Last`=1) and PRI1 (`Last`=0).
- Only Full0 set: grant 0.
- Only Full1 set: grant 1.
- Both set: grant the channel that is not `Last`.
- After any grant, `Last` ← the granted channel. With no grant, `Last` holds.

**Output register**
- On a grant: `Write_En` ← 1, and `Add_Dest`/`Write_Data` ← the granted buffer's contents. The granted buffer clears unless it is refilled in the same edge.
- With no grant: `Write_En` ← 0, and `Add_Dest`/`Write_Data` hold their values.

**Hazards (combinational)**
- `Hazard_A` = (Add_A != 0) && (Add_A matches Dest0 with Full0, or Dest1 with Full1, or `Add_Dest` with `Write_En`).
- `Hazard_B`: same as `Hazard_A`, using `Add_B`.

**Flush**
- Clears Full0 and Full1, and any acceptance in that cycle is ignored.
- The output register still issues a write already granted before the flush; `Write_En` becomes 0 on the flush edge.
- `Last` is unchanged.

**Reset**
- `Write_En`=0, `Add_Dest`=0, `Write_Data`=0.
- Full0=Full1=0, `Last`=1 (channel 0 has priority first).
- Therefore `Req0_Ready`=`Req1_Ready`=1 and `Hazard_A`/`Hazard_B`=0.
- Reset mid-operation discards buffered and in-flight writes immediately, asynchronously.

## Timing
- Accept at edge N. Grant is possible in cycle N..N+1, registered at edge N+1 (`Write_En`=1 during cycle N+1). The register file commits at edge N+2.
- Minimum latency from request to register-file commit is two edges.
- Throughput is one write per cycle in aggregate.
- Under continuous contention each channel sustains one write every two cycles. Neither channel waits more than one grant.
- Simultaneous requests to the same Dest from both channels are serialised in grant order, so the last granted value wins.
- `Hazard_*` reflect state within the same cycle and carry no added latency.

## Structure
- Shared package `rv_pkg`: `DATA_W`, `ADDR_W`, the register-zero constant, and the writeback-request struct (valid, dest, data).
- Natural sub-module: `wb_hold_buf`, the one-entry buffer with Ready logic and x0 drop, instantiated twice.
- The scheduler, output register and hazard compare live in the top module.

## Test plan
1. After reset, with no requests: `Write_En`=0, both Ready=1, both Hazard=0.
2. Req0 (Dest=1, Data=20) alone at edge N → `Write_En`=1, `Add_Dest`=1, `Write_Data`=20 in cycle N+1; reading register 1 afterwards returns 20.
3. Both channels valid every cycle (Req0 Dest=2/Data=25, Req1 Dest=3/Data=5) → the output alternates 2, 3, 2, 3, starting with channel 0.
4. Req1 with Dest=0, Data=30 → Req1_Ready=1, `Write_En` stays 0, register 0 remains 0.
5. Req0 Dest=7 accepted with `Add_A`=7, `Add_B`=4 → `Hazard_A`=1 until `Write_En` drops after the write; `Hazard_B`=0 throughout.
6. Both buffers full, then `Flush` is pulsed → one write is still issued (already granted), and afterwards Full0=Full1=0. Asserting `RST` mid-stream forces `Write_En`=0 immediately.
